// File: rtl/fp_pkg.sv
// +------------------------------------------------------------------+
// | fp_pkg: shared FP32 types, constants and accumulator FSM states.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package fp_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [22:0] frac;
  } fp32_t;

  localparam fp32_t FP32_ZERO = 32'h0000_0000;
  localparam fp32_t FP32_ONE  = 32'h3F80_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    EMIT = 2'd2
  } accum_state_t;

endpackage

`default_nettype wire

// File: rtl/fp_accum_ctrl.sv
// +------------------------------------------------------------------+
// | fp_accum_ctrl: sequences an operand stream through an external    |
// | FP32 adder and emits one accumulated sum per group.              |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module fp_accum_ctrl
  import fp_pkg::*;
#(
  parameter int ADD_LATENCY = 1,
  parameter int COUNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_data,
  input  logic               in_last,
  output logic [31:0]        add_op1,
  output logic [31:0]        add_op2,
  input  logic [31:0]        add_result,
  input  logic               add_overflow,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_sum,
  output logic [COUNT_W-1:0] out_count,
  output logic               out_overflow
);

  localparam int                 TIMER_W      = 4;
  localparam logic [TIMER_W-1:0] C_TIMER_LOAD = TIMER_W'(ADD_LATENCY - 1);
  localparam logic [COUNT_W-1:0] C_COUNT_MAX  = '1;

  accum_state_t       r_state;
  accum_state_t       w_state_nxt;
  fp32_t              r_acc;
  fp32_t              r_op2;
  logic [COUNT_W-1:0] r_count;
  logic               r_ovf;
  logic               r_last_q;
  logic [TIMER_W-1:0] r_timer;

  logic w_accept;
  logic w_first;
  logic w_capture;
  logic w_drain;

  assign w_accept  = in_valid && in_ready;
  assign w_first   = (r_count == '0);
  assign w_capture = (r_state == WAIT) && (r_timer == '0);
  assign w_drain   = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (!w_first) begin
            w_state_nxt = WAIT;
          end else if (in_last) begin
            w_state_nxt = EMIT;
          end
        end
      end
      WAIT: begin
        if (w_capture) begin
          w_state_nxt = r_last_q ? EMIT : IDLE;
        end
      end
      EMIT: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // in_ready is gated by rst directly so nothing is accepted while reset is held
  always_comb begin
    in_ready     = (r_state == IDLE) && !rst;
    out_valid    = (r_state == EMIT);
    add_op1      = r_acc;
    add_op2      = r_op2;
    out_sum      = r_acc;
    out_count    = r_count;
    out_overflow = r_ovf;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= FP32_ZERO;
      r_op2    <= FP32_ZERO;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_last_q <= 1'b0;
      r_timer  <= '0;
    end else begin
      if (w_accept) begin
        // first operand of a group seeds the accumulator without an add
        if (w_first) begin
          r_acc   <= in_data;
          r_count <= COUNT_W'(1);
        end else begin
          r_op2    <= in_data;
          r_last_q <= in_last;
          r_timer  <= C_TIMER_LOAD;
        end
      end
      if ((r_state == WAIT) && (r_timer != '0)) begin
        r_timer <= r_timer - 1'b1;
      end
      if (w_capture) begin
        r_acc <= add_result;
        if (r_count != C_COUNT_MAX) begin
          r_count <= r_count + 1'b1;
        end
        r_ovf <= r_ovf | add_overflow | (r_count == C_COUNT_MAX);
      end
      if (w_drain) begin
        r_acc   <= FP32_ZERO;
        r_count <= '0;
        r_ovf   <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/fp_accum_ctrl.md
Name: fp_accum_ctrl

Overview:
Sequencing stage wrapped around the combinational FP32 add/subtract block. It accepts a stream of IEEE-754 single-precision operands over a valid/ready handshake and drives add_op1 (running sum) and add_op2 (new operand) into the adder. After a fixed settle window it captures add_result back into the accumulator, and emits one sum per group when in_last is seen. The adder is instantiated beside this block at the top level, not inside it.

Parameters:
ADD_LATENCY, 1, cycles add_op1/add_op2 are held stable before add_result is sampled (legal range 1..15)
COUNT_W, 8, width of the element counter

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset: one clock; reset is asynchronous and active-high
in_valid  input  1  operand valid
in_ready  output  1  operand accepted when in_valid && in_ready
in_data  input  32  FP32 operand
in_last  input  1  marks final operand of a group; qualified by the accept
add_op1  output  32  to adder op1 (registered accumulator)
add_op2  output  32  to adder op2 (registered operand)
add_result  input  32  from adder
add_overflow  input  1  from adder, sampled only at capture
out_valid  output  1  group result valid
out_ready  input  1  downstream accepts when out_valid && out_ready
out_sum  output  32  group FP32 sum
out_count  output  COUNT_W  operands in group, saturating
out_overflow  output  1  sticky: any captured add_overflow, or counter saturated

Behaviour:
- Reset (async assert, sync release): state IDLE, acc/add_op1/add_op2/out_sum = 0, count/out_count = 0, out_overflow = 0, out_valid = 0, last_q = 0, timer = 0. in_ready = 0 while rst is high.
- States: IDLE, WAIT, EMIT. in_ready = (state == IDLE) && !rst. out_valid = (state == EMIT).
- IDLE, accept with count == 0: acc <= in_data, count <= 1, no adder use. Next state is EMIT if in_last, else IDLE.
- IDLE, accept with count != 0: add_op2 <= in_data, last_q <= in_last, timer <= ADD_LATENCY-1, next state WAIT.
- WAIT with timer != 0: timer decrements. add_op1 and add_op2 are held constant.
- WAIT with timer == 0: acc <= add_result, count <= count+1 saturating at all-ones, ovf <= ovf | add_overflow | (count == all-ones). Next state is EMIT if last_q, else IDLE.
- add_op1 always equals acc. No combinational path exists from in_data to add_op1 or add_op2.
- Throughput: the first operand takes 1 cycle; each further operand takes 1 + ADD_LATENCY cycles. out_valid asserts in the cycle after the final capture, or after the first-element accept for a single-operand group.
- EMIT: out_sum, out_count and out_overflow are driven from acc, count and ovf and stay stable while out_ready is low. On out_valid && out_ready: acc, count and ovf clear to 0, next state IDLE. A new operand can be accepted in the following cycle.
- The adder's arithmetic is not modified. Zero, negative and cancelling operands are passed through unchanged.
- Reset mid-WAIT or mid-EMIT: the group is discarded, no partial output is produced, and all values return to reset values immediately.
- Stall behaviour: in_valid low in IDLE holds all state. in_last on a non-accepted cycle is ignored.

Decomposition:
- Shared package fp_pkg:
  - fp32_t packed struct {sign, exp[7:0], frac[22:0]}
  - constants FP32_ZERO and FP32_ONE (0x3F800000)
  - accum_state_t enum {IDLE, WAIT, EMIT}
- No sub-module. The latency timer and FSM are small enough to sit inline.
- Bench top: fp_accum_ctrl wired to addsub.

Test Plan:
- ADD_LATENCY=1. Send 0x3F800000 (1.0) then 0x40000000 (2.0, last) → out_sum 0x40400000, out_count 2, out_overflow 0. out_valid asserts 3 cycles after the first accept.
- Single operand 0x40A00000 with last → out_sum 0x40A00000, out_count 1, out_valid on the next cycle. add_op2 is not updated.
- 0x3F800000 then 0xBF800000 (-1.0, last) → out_sum 0x00000000, out_count 2.
- ADD_LATENCY=3, group {0x3F000000, 0x3FC00000, 0x3F800000} → add_op2 stable for exactly 3 cycles per add. out_sum 0x40400000 (3.0), out_count 3. in_ready is low for 3 cycles after each non-first accept.
- Backpressure: hold out_ready low for 5 cycles in EMIT → out_valid stays high, out_sum is stable, in_ready is 0. Raise out_ready → the next cycle is IDLE with count 0.
- Assert rst during WAIT of a 2-operand group → all outputs go to 0 without waiting for a clock edge. After release, group {0x40000000 last} emits 0x40000000, count 1.
